pipe_stage_buffer: RTL and testbench

//  Parametrised inter-stage pipeline register for the pipelined MIPS datapath
//  (IF/ID, ID/EX, EX/MEM, MEM/WB). Carries control bits, N data lanes and the

---
 rtl/pipe_stage_buffer_if.sv | 35 +++
 rtl/pipe_stage_buffer.sv | 65 ++++++
 tb/tb_pipe_stage_buffer.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_buffer_if.sv
// Signal bundle between a pipeline stage buffer and the datapath around it.
// The master side feeds instructions and hazard controls; the slave side is the buffer.
interface pipe_stage_buffer_if #(
    parameter int DATA_W = 32,
    parameter int N_DATA = 2,
    parameter int CTRL_W = 2,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
);
    // No ready: in_valid only marks real instructions vs bubbles, and the
    // producer is held back by the same stall that freezes this buffer.
    logic                     in_valid;
    logic                     in_regw;
    logic [CTRL_W-1:0]        in_ctrl;
    logic [N_DATA*DATA_W-1:0] in_data;
    logic [REG_W-1:0]         in_rd;
    logic                     stall;
    logic                     flush;
    logic                     out_valid;
    logic                     out_regw;
    logic [CTRL_W-1:0]        out_ctrl;
    logic [N_DATA*DATA_W-1:0] out_data;
    logic [REG_W-1:0]         out_rd;
    logic [CNT_W-1:0]         stall_cnt;

    modport master (
        output in_valid, in_regw, in_ctrl, in_data, in_rd, stall, flush,
        input  out_valid, out_regw, out_ctrl, out_data, out_rd, stall_cnt
    );

    modport slave (
        input  in_valid, in_regw, in_ctrl, in_data, in_rd, stall, flush,
        output out_valid, out_regw, out_ctrl, out_data, out_rd, stall_cnt
    );
endinterface

// File: rtl/pipe_stage_buffer.sv
// Inter-stage pipeline register chain (DEPTH stages) with reset, stall, flush,
// per-stage valid and a saturating stall-cycle counter.
module pipe_stage_buffer #(
    parameter int DATA_W = 32,
    parameter int N_DATA = 2,
    parameter int CTRL_W = 2,
    parameter int REG_W  = 5,
    parameter int DEPTH  = 1,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pipe_stage_buffer_if.slave   bus
);
    typedef struct packed {
        logic                     valid;
        logic                     regw;
        logic [CTRL_W-1:0]        ctrl;
        logic [N_DATA*DATA_W-1:0] data;
        logic [REG_W-1:0]         rd;
    } stage_t;

    stage_t           stages [DEPTH];
    stage_t           inEntry;
    logic [CNT_W-1:0] stallCnt;

    // Bubbles carry no write intent or control, whatever the decoder drove.
    always_comb begin
        inEntry       = '0;
        inEntry.valid = bus.in_valid;
        inEntry.regw  = bus.in_valid & bus.in_regw;
        inEntry.ctrl  = bus.in_valid ? bus.in_ctrl : '0;
        inEntry.data  = bus.in_data;
        inEntry.rd    = bus.in_rd;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || bus.flush) begin
            for (int k = 0; k < DEPTH; k++) begin
                stages[k] <= '0;
            end
        end else if (!bus.stall) begin
            stages[0] <= inEntry;
            for (int k = 1; k < DEPTH; k++) begin
                stages[k] <= stages[k-1];
            end
        end
    end

    // A flushed cycle is not a stall cycle, even when both are requested.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stallCnt <= '0;
        end else if (bus.stall && !bus.flush && (stallCnt != {CNT_W{1'b1}})) begin
            stallCnt <= stallCnt + 1'b1;
        end
    end

    assign bus.out_valid = stages[DEPTH-1].valid;
    assign bus.out_regw  = stages[DEPTH-1].regw & stages[DEPTH-1].valid;
    assign bus.out_ctrl  = stages[DEPTH-1].ctrl;
    assign bus.out_data  = stages[DEPTH-1].data;
    assign bus.out_rd    = stages[DEPTH-1].rd;
    assign bus.stall_cnt = stallCnt;
endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Bench for pipe_stage_buffer: a DEPTH=3/CNT_W=4 and a DEPTH=1/CNT_W=16 instance
// share one stimulus stream and are checked against an instruction-history model.
module tb_pipe_stage_buffer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_regw, stall, flush;
    logic [1:0]  in_ctrl;
    logic [63:0] in_data;
    logic [4:0]  in_rd;

    int checks = 0;
    int failures = 0;
    int cycle = 0;
    int stalls = 0;
    logic [72:0] hist[$];

    always #5 clk = ~clk;

    pipe_stage_buffer_if #(.CNT_W(4))  ifA ();
    pipe_stage_buffer_if #(.CNT_W(16)) ifB ();

    assign ifA.in_valid = in_valid;
    assign ifA.in_regw  = in_regw;
    assign ifA.in_ctrl  = in_ctrl;
    assign ifA.in_data  = in_data;
    assign ifA.in_rd    = in_rd;
    assign ifA.stall    = stall;
    assign ifA.flush    = flush;
    assign ifB.in_valid = in_valid;
    assign ifB.in_regw  = in_regw;
    assign ifB.in_ctrl  = in_ctrl;
    assign ifB.in_data  = in_data;
    assign ifB.in_rd    = in_rd;
    assign ifB.stall    = stall;
    assign ifB.flush    = flush;

    pipe_stage_buffer #(.DEPTH(3), .CNT_W(4))  dutA (.clk(clk), .rst_n(rst_n), .bus(ifA));
    pipe_stage_buffer #(.DEPTH(1), .CNT_W(16)) dutB (.clk(clk), .rst_n(rst_n), .bus(ifB));

    wire [72:0] obsA = {ifA.out_valid, ifA.out_regw, ifA.out_ctrl, ifA.out_data, ifA.out_rd};
    wire [72:0] obsB = {ifB.out_valid, ifB.out_regw, ifB.out_ctrl, ifB.out_data, ifB.out_rd};

    // Model: the output is the instruction accepted d advancing cycles ago;
    // a flush inserts enough bubbles to cover the deepest instance.
    function automatic logic [72:0] exp_out(input int d);
        if (hist.size() >= d) return hist[hist.size() - d];
        return '0;
    endfunction

    function automatic logic [3:0] exp_cnt_a();
        return (stalls > 15) ? 4'd15 : 4'(stalls);
    endfunction

    function automatic logic [15:0] exp_cnt_b();
        return (stalls > 65535) ? 16'hFFFF : 16'(stalls);
    endfunction

    task automatic drive(input logic v, input logic r, input logic [1:0] c,
                         input logic [63:0] d, input logic [4:0] rd_i,
                         input logic st, input logic fl);
        in_valid = v; in_regw = r; in_ctrl = c; in_data = d; in_rd = rd_i;
        stall = st; flush = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            hist.delete();
            stalls = 0;
        end else if (flush) begin
            for (int i = 0; i < 3; i++) hist.push_back('0);
        end else if (stall) begin
            stalls++;
        end else begin
            hist.push_back({in_valid, in_regw & in_valid, in_valid ? in_ctrl : 2'b00, in_data, in_rd});
        end
        while (hist.size() > 4) void'(hist.pop_front());
        cycle++;
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: begin rst_n = 1'b0; drive(1, 1, 2'b11, {$urandom(), $urandom()}, 5'd7, 0, 0); end
                1: begin rst_n = 1'b1; drive(1, 1, 2'b01, 64'h0000_0000_DEAD_BEEF, 5'd5, 0, 0); end
                default: drive(0, 0, 2'b00, 64'h0, 5'd0, 0, 0);
            endcase
            tick();
            checks += 4;
            if (obsA !== exp_out(3)) begin failures++; $display("FAIL reset_pipeA cyc=%0d got=%h exp=%h", cycle, obsA, exp_out(3)); end
            if (obsB !== exp_out(1)) begin failures++; $display("FAIL reset_pipeB cyc=%0d got=%h exp=%h", cycle, obsB, exp_out(1)); end
            if (ifA.stall_cnt !== exp_cnt_a()) begin failures++; $display("FAIL reset_cntA cyc=%0d got=%0d exp=%0d", cycle, ifA.stall_cnt, exp_cnt_a()); end
            if (ifB.stall_cnt !== exp_cnt_b()) begin failures++; $display("FAIL reset_cntB cyc=%0d got=%0d exp=%0d", cycle, ifB.stall_cnt, exp_cnt_b()); end
            if (i == 0) begin
                checks++;
                if ({obsA, obsB, ifA.stall_cnt, ifB.stall_cnt} !== '0) begin
                    failures++; $display("FAIL reset_zero got=%h/%h/%0d/%0d exp=0", obsA, obsB, ifA.stall_cnt, ifB.stall_cnt);
                end
            end
            if (i == 1) begin
                checks++;
                if (ifB.out_data[31:0] !== 32'hDEADBEEF || ifB.out_rd !== 5'd5 || ifB.out_regw !== 1'b1) begin
                    failures++; $display("FAIL reset_loadB got=%h/%0d/%b exp=deadbeef/5/1", ifB.out_data[31:0], ifB.out_rd, ifB.out_regw);
                end
            end
            if (i == 3) begin
                checks++;
                if (ifA.out_data[31:0] !== 32'hDEADBEEF || ifA.out_rd !== 5'd5 || ifA.out_regw !== 1'b1) begin
                    failures++; $display("FAIL reset_loadA got=%h/%0d/%b exp=deadbeef/5/1", ifA.out_data[31:0], ifA.out_rd, ifA.out_regw);
                end
            end
        end
    endtask

    task automatic test_stall();
        logic [72:0] prevA, prevB;
        int seen[$];
        for (int i = 0; i < 11; i++) begin
            rst_n = (i != 0);
            prevA = obsA;
            prevB = obsB;
            case (i)
                0:    drive(0, 0, 2'b00, 64'h0, 5'd0, 0, 0);
                1:    drive(1, 1, 2'b01, {$urandom(), $urandom()}, 5'd1, 0, 0);
                2:    drive(1, 0, 2'b10, {$urandom(), $urandom()}, 5'd2, 0, 0);
                3, 4: drive(1, 1, 2'b11, {$urandom(), $urandom()}, 5'd9, 1, 0);
                5:    drive(1, 1, 2'b00, {$urandom(), $urandom()}, 5'd3, 0, 0);
                6:    drive(1, 1, 2'b01, {$urandom(), $urandom()}, 5'd4, 0, 0);
                default: drive(0, 0, 2'b00, 64'h0, 5'd0, 0, 0);
            endcase
            tick();
            checks += 4;
            if (obsA !== exp_out(3)) begin failures++; $display("FAIL stall_pipeA cyc=%0d got=%h exp=%h", cycle, obsA, exp_out(3)); end
            if (obsB !== exp_out(1)) begin failures++; $display("FAIL stall_pipeB cyc=%0d got=%h exp=%h", cycle, obsB, exp_out(1)); end
            if (ifA.stall_cnt !== exp_cnt_a()) begin failures++; $display("FAIL stall_cntA cyc=%0d got=%0d exp=%0d", cycle, ifA.stall_cnt, exp_cnt_a()); end
            if (ifB.stall_cnt !== exp_cnt_b()) begin failures++; $display("FAIL stall_cntB cyc=%0d got=%0d exp=%0d", cycle, ifB.stall_cnt, exp_cnt_b()); end
            if (i == 3 || i == 4) begin
                checks++;
                if (obsA !== prevA || obsB !== prevB) begin
                    failures++; $display("FAIL stall_frozen cyc=%0d got=%h/%h exp=%h/%h", cycle, obsA, obsB, prevA, prevB);
                end
            end else if (ifA.out_valid === 1'b1) begin
                seen.push_back(int'(ifA.out_rd));
            end
        end
        checks += 2;
        if (seen.size() != 4 || seen[0] != 1 || seen[1] != 2 || seen[2] != 3 || seen[3] != 4) begin
            failures++; $display("FAIL stall_order got=%p exp=1,2,3,4", seen);
        end
        if (ifA.stall_cnt !== 4'd2 || ifB.stall_cnt !== 16'd2) begin
            failures++; $display("FAIL stall_count got=%0d/%0d exp=2/2", ifA.stall_cnt, ifB.stall_cnt);
        end
    endtask

    task automatic test_flush();
        logic [3:0] cntBefore;
        for (int i = 0; i < 8; i++) begin
            rst_n = 1'b1;
            if (i == 3) cntBefore = ifA.stall_cnt;
            if (i == 3) drive(1, 1, 2'b11, {$urandom(), $urandom()}, 5'd17, 1, 1);
            else        drive(1, 1, 2'($urandom_range(0, 3)), {$urandom(), $urandom()}, 5'($urandom_range(1, 31)), 0, 0);
            tick();
            checks += 4;
            if (obsA !== exp_out(3)) begin failures++; $display("FAIL flush_pipeA cyc=%0d got=%h exp=%h", cycle, obsA, exp_out(3)); end
            if (obsB !== exp_out(1)) begin failures++; $display("FAIL flush_pipeB cyc=%0d got=%h exp=%h", cycle, obsB, exp_out(1)); end
            if (ifA.stall_cnt !== exp_cnt_a()) begin failures++; $display("FAIL flush_cntA cyc=%0d got=%0d exp=%0d", cycle, ifA.stall_cnt, exp_cnt_a()); end
            if (ifB.stall_cnt !== exp_cnt_b()) begin failures++; $display("FAIL flush_cntB cyc=%0d got=%0d exp=%0d", cycle, ifB.stall_cnt, exp_cnt_b()); end
            if (i >= 3 && i <= 5) begin
                checks++;
                if (ifA.out_valid !== 1'b0 || ifA.out_regw !== 1'b0 || ifA.out_data !== 64'h0 || ifA.stall_cnt !== cntBefore) begin
                    failures++; $display("FAIL flush_bubble cyc=%0d got=%b/%b/%h/%0d exp=0/0/0/%0d", cycle,
                                         ifA.out_valid, ifA.out_regw, ifA.out_data, ifA.stall_cnt, cntBefore);
                end
            end
        end
    endtask

    task automatic test_bubble();
        for (int i = 0; i < 4; i++) begin
            rst_n = 1'b1;
            if (i == 0) drive(0, 1, 2'b11, {$urandom(), $urandom()}, 5'd12, 0, 0);
            else        drive(1, 0, 2'b00, {$urandom(), $urandom()}, 5'd3, 0, 0);
            tick();
            checks += 2;
            if (obsA !== exp_out(3)) begin failures++; $display("FAIL bubble_pipeA cyc=%0d got=%h exp=%h", cycle, obsA, exp_out(3)); end
            if (obsB !== exp_out(1)) begin failures++; $display("FAIL bubble_pipeB cyc=%0d got=%h exp=%h", cycle, obsB, exp_out(1)); end
            if (i == 0 || i == 2) begin
                checks++;
                if ((i == 0 ? {ifB.out_valid, ifB.out_regw, ifB.out_ctrl} : {ifA.out_valid, ifA.out_regw, ifA.out_ctrl}) !== 4'b0000) begin
                    failures++; $display("FAIL bubble_ctrl cyc=%0d gotA=%b%b%b gotB=%b%b%b exp=0000", cycle,
                                         ifA.out_valid, ifA.out_regw, ifA.out_ctrl, ifB.out_valid, ifB.out_regw, ifB.out_ctrl);
                end
            end
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 21; i++) begin
            rst_n = (i != 0);
            drive(1, 1, 2'b01, {$urandom(), $urandom()}, 5'd8, (i != 0), 0);
            tick();
            checks += 2;
            if (ifA.stall_cnt !== exp_cnt_a()) begin failures++; $display("FAIL sat_cntA cyc=%0d got=%0d exp=%0d", cycle, ifA.stall_cnt, exp_cnt_a()); end
            if (ifB.stall_cnt !== exp_cnt_b()) begin failures++; $display("FAIL sat_cntB cyc=%0d got=%0d exp=%0d", cycle, ifB.stall_cnt, exp_cnt_b()); end
        end
        checks++;
        if (ifA.stall_cnt !== 4'd15 || ifB.stall_cnt !== 16'd20) begin
            failures++; $display("FAIL sat_final got=%0d/%0d exp=15/20", ifA.stall_cnt, ifB.stall_cnt);
        end
    endtask

    task automatic test_reset_mid_stall();
        for (int i = 0; i < 7; i++) begin
            rst_n = (i != 5);
            drive(1, 1, 2'b10, {$urandom(), $urandom()}, 5'($urandom_range(1, 31)), (i >= 3), 0);
            tick();
            checks += 4;
            if (obsA !== exp_out(3)) begin failures++; $display("FAIL rstmid_pipeA cyc=%0d got=%h exp=%h", cycle, obsA, exp_out(3)); end
            if (obsB !== exp_out(1)) begin failures++; $display("FAIL rstmid_pipeB cyc=%0d got=%h exp=%h", cycle, obsB, exp_out(1)); end
            if (ifA.stall_cnt !== exp_cnt_a()) begin failures++; $display("FAIL rstmid_cntA cyc=%0d got=%0d exp=%0d", cycle, ifA.stall_cnt, exp_cnt_a()); end
            if (ifB.stall_cnt !== exp_cnt_b()) begin failures++; $display("FAIL rstmid_cntB cyc=%0d got=%0d exp=%0d", cycle, ifB.stall_cnt, exp_cnt_b()); end
            if (i == 5) begin
                checks++;
                if ({obsA, obsB, ifA.stall_cnt, ifB.stall_cnt} !== '0) begin
                    failures++; $display("FAIL rstmid_zero got=%h/%h/%0d/%0d exp=0", obsA, obsB, ifA.stall_cnt, ifB.stall_cnt);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst_n = ($urandom_range(0, 63) != 0);
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom()), 2'($urandom()), {$urandom(), $urandom()},
                  5'($urandom()), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 15) == 0));
            tick();
            checks += 4;
            if (obsA !== exp_out(3)) begin failures++; $display("FAIL rand_pipeA cyc=%0d got=%h exp=%h", cycle, obsA, exp_out(3)); end
            if (obsB !== exp_out(1)) begin failures++; $display("FAIL rand_pipeB cyc=%0d got=%h exp=%h", cycle, obsB, exp_out(1)); end
            if (ifA.stall_cnt !== exp_cnt_a()) begin failures++; $display("FAIL rand_cntA cyc=%0d got=%0d exp=%0d", cycle, ifA.stall_cnt, exp_cnt_a()); end
            if (ifB.stall_cnt !== exp_cnt_b()) begin failures++; $display("FAIL rand_cntB cyc=%0d got=%0d exp=%0d", cycle, ifB.stall_cnt, exp_cnt_b()); end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 2'b00, 64'h0, 5'd0, 0, 0);
        @(negedge clk);
        test_reset();
        test_stall();
        test_flush();
        test_bubble();
        test_saturation();
        test_reset_mid_stall();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
